// File: rtl/exc_ctrl.sv
// exc_ctrl - exception/interrupt controller at the MEM/commit stage.
//
// Picks the highest-priority event for the committing instruction. The
// candidates are a pending hardware interrupt, a synchronous exception or
// ERET. The controller then spends one WRITE cycle driving the CP0 write side
// (Status/Cause/EPC/BadVAddr) together with a PC redirect. After that it holds
// the pipeline flush for FLUSH_CYCLES more cycles before it accepts new events.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   valid_in, pc_in     committing instruction and its PC
//   is_delay_slot       instruction sits in a branch delay slot
//   exc_flags[6:0]      fetch AdEL, RI, Ov, Syscall, Break, data AdEL, data AdES
//   data_badaddr        faulting data address
//   eret                instruction is ERET
//   hw_int[5:0]         raw asynchronous interrupt lines
//   status_in, epc_in   current CP0 Status / EPC
//   cp0_*               CP0 write strobes (bit n = register n) and field values
//   flush               kill IF..MEM contents
//   redirect_valid/pc   load new fetch PC
//   busy                controller not idle
module exc_ctrl #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int               FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             is_delay_slot,
  input  logic [6:0]       exc_flags,
  input  logic [WIDTH-1:0] data_badaddr,
  input  logic             eret,
  input  logic [5:0]       hw_int,
  input  logic [WIDTH-1:0] status_in,
  input  logic [WIDTH-1:0] epc_in,
  output logic [WIDTH-1:0] cp0_we,
  output logic [WIDTH-1:0] cp0_epc,
  output logic [WIDTH-1:0] cp0_badaddr,
  output logic [4:0]       cp0_exccode,
  output logic             cp0_branch_delay,
  output logic [5:0]       cp0_hw_int,
  output logic [1:0]       cp0_sw_int,
  output logic [7:0]       cp0_int_enable,
  output logic             cp0_exl,
  output logic             cp0_ie,
  output logic             flush,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             busy
);

  localparam int CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);

  typedef enum logic [1:0] {IDLE, WRITE, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [5:0]       sync1_q, sync2_q;
  logic             isEret_q, addrErr_q, bd_q;
  logic [4:0]       code_q;
  logic [WIDTH-1:0] pc_q, bad_q;
  logic [5:0]       intLines_q;

  logic             intPending;
  logic             evtValid;
  logic             evtEret;
  logic             evtAddrErr;
  logic [4:0]       evtCode;
  logic [WIDTH-1:0] evtBad;
  logic             unusedStatus;

  // Only IM, EXL and IE of Status matter here.
  assign unusedStatus = ^{status_in[WIDTH-1:16], status_in[7:2]};

  // Two-flop synchroniser for the asynchronous interrupt lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= hw_int;
      sync2_q <= sync1_q;
    end
  end

  assign intPending = (|(sync2_q & status_in[15:10])) & status_in[0] & ~status_in[1];

  // Priority select. Interrupts win, then the exceptions in pipeline order,
  // and ERET only when nothing else is raised.
  always_comb begin
    evtEret    = 1'b0;
    evtAddrErr = 1'b0;
    evtCode    = 5'd0;
    evtBad     = '0;
    if (intPending) begin
      evtCode = 5'd0;
    end else if (exc_flags[0]) begin
      evtCode    = 5'd4;
      evtAddrErr = 1'b1;
      evtBad     = pc_in;
    end else if (exc_flags[1]) begin
      evtCode = 5'd10;
    end else if (exc_flags[2]) begin
      evtCode = 5'd12;
    end else if (exc_flags[3]) begin
      evtCode = 5'd8;
    end else if (exc_flags[4]) begin
      evtCode = 5'd9;
    end else if (exc_flags[5]) begin
      evtCode    = 5'd4;
      evtAddrErr = 1'b1;
      evtBad     = data_badaddr;
    end else if (exc_flags[6]) begin
      evtCode    = 5'd5;
      evtAddrErr = 1'b1;
      evtBad     = data_badaddr;
    end else if (eret) begin
      evtEret = 1'b1;
    end
  end

  assign evtValid = valid_in & (intPending | (|exc_flags) | eret);

  // State register and flush counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Event capture. It happens only on acceptance so the WRITE cycle drives
  // purely registered data and nothing from valid_in reaches the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isEret_q   <= 1'b0;
      addrErr_q  <= 1'b0;
      bd_q       <= 1'b0;
      code_q     <= '0;
      pc_q       <= '0;
      bad_q      <= '0;
      intLines_q <= '0;
    end else if (state_q == IDLE && evtValid) begin
      isEret_q   <= evtEret;
      addrErr_q  <= evtAddrErr;
      bd_q       <= is_delay_slot;
      code_q     <= evtCode;
      pc_q       <= pc_in;
      bad_q      <= evtBad;
      intLines_q <= sync2_q;
    end
  end

  // Next-state logic. In WRITE the counter is loaded so that FLUSH lasts
  // exactly FLUSH_CYCLES cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (evtValid) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = FLUSH;
        cnt_d   = CW'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode from the state alone, so reset clears them immediately.
  // ERET writes only Status and clears EXL. The other fields stay zero.
  always_comb begin
    cp0_we           = '0;
    cp0_epc          = '0;
    cp0_badaddr      = '0;
    cp0_exccode      = '0;
    cp0_branch_delay = 1'b0;
    cp0_hw_int       = '0;
    cp0_sw_int       = '0;
    cp0_int_enable   = '0;
    cp0_exl          = 1'b0;
    cp0_ie           = 1'b0;
    flush            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    busy             = 1'b0;
    case (state_q)
      WRITE: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        busy           = 1'b1;
        cp0_ie         = status_in[0];
        cp0_int_enable = status_in[15:8];
        if (isEret_q) begin
          cp0_we[12]  = 1'b1;
          redirect_pc = epc_in;
        end else begin
          cp0_we[12]       = 1'b1;
          cp0_we[13]       = 1'b1;
          cp0_we[14]       = 1'b1;
          cp0_we[8]        = addrErr_q;
          cp0_exl          = 1'b1;
          cp0_epc          = pc_q;
          cp0_badaddr      = bad_q;
          cp0_exccode      = code_q;
          cp0_branch_delay = bd_q;
          cp0_hw_int       = intLines_q & status_in[15:10];
          redirect_pc      = EXC_VECTOR;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        busy  = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl - directed and randomized checks of exc_ctrl against a
// behavioural model of the priority/CP0-write rules.
module tb_exc_ctrl;

  localparam int          WIDTH = 32;
  localparam logic [31:0] VEC   = 32'hBFC00380;
  localparam int          FC    = 2;

  logic        clk, rst;
  logic        valid_in, is_delay_slot, eret;
  logic [31:0] pc_in, data_badaddr, status_in, epc_in;
  logic [6:0]  exc_flags;
  logic [5:0]  hw_int;
  logic [31:0] cp0_we, cp0_epc, cp0_badaddr, redirect_pc;
  logic [4:0]  cp0_exccode;
  logic        cp0_branch_delay, cp0_exl, cp0_ie, flush, redirect_valid, busy;
  logic [5:0]  cp0_hw_int;
  logic [1:0]  cp0_sw_int;
  logic [7:0]  cp0_int_enable;

  int assertCount = 0;
  int failCount   = 0;

  // Model: raw interrupt samples taken at each clock edge, newest first.
  logic [5:0] hwHist[$];

  // Expected WRITE-cycle values.
  logic        expAccept;
  logic [31:0] expWe, expEpc, expBad, expRpc;
  logic [4:0]  expCode;
  logic        expBd, expExl, expIe;
  logic [5:0]  expHw;
  logic [7:0]  expIntEn;

  exc_ctrl #(.WIDTH(WIDTH), .EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in),
    .is_delay_slot(is_delay_slot), .exc_flags(exc_flags),
    .data_badaddr(data_badaddr), .eret(eret), .hw_int(hw_int),
    .status_in(status_in), .epc_in(epc_in), .cp0_we(cp0_we),
    .cp0_epc(cp0_epc), .cp0_badaddr(cp0_badaddr), .cp0_exccode(cp0_exccode),
    .cp0_branch_delay(cp0_branch_delay), .cp0_hw_int(cp0_hw_int),
    .cp0_sw_int(cp0_sw_int), .cp0_int_enable(cp0_int_enable),
    .cp0_exl(cp0_exl), .cp0_ie(cp0_ie), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hwHist.delete();
    end else begin
      hwHist.push_front(hw_int);
      if (hwHist.size() > 4) void'(hwHist.pop_back());
    end
  end

  // An interrupt line is visible two edges after it was sampled.
  function automatic logic [5:0] syncedLines();
    if (hwHist.size() >= 2) return hwHist[1];
    return 6'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Build the expected CP0 write from the priority rules, present the
  // instruction for one edge and then withdraw it.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic ds,
                               input logic [6:0] flags, input logic [31:0] bad,
                               input logic er);
    int          codes[7] = '{4, 10, 12, 8, 9, 4, 5};
    logic [5:0]  lines;
    logic        pend, found, isAddr;
    lines = syncedLines();
    pend  = (|(lines & status_in[15:10])) && status_in[0] && !status_in[1];
    expAccept = v && (pend || flags != 7'd0 || er);
    expWe = 0; expEpc = 0; expBad = 0; expCode = 0; expBd = 0; expExl = 0;
    expHw = 0; expRpc = 0;
    expIe    = status_in[0];
    expIntEn = status_in[15:8];
    found  = pend;
    isAddr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (!found && flags[i]) begin
        found   = 1'b1;
        expCode = 5'(codes[i]);
        isAddr  = (i == 0 || i == 5 || i == 6);
        if (i == 0) expBad = pc;
        else if (isAddr) expBad = bad;
      end
    end
    if (found) begin
      expWe  = (32'd1 << 12) | (32'd1 << 13) | (32'd1 << 14) | (isAddr ? (32'd1 << 8) : 32'd0);
      expExl = 1'b1;
      expEpc = pc;
      expBd  = ds;
      expHw  = lines & status_in[15:10];
      expRpc = VEC;
    end else begin
      expWe  = 32'd1 << 12;
      expRpc = epc_in;
    end
    valid_in = v; pc_in = pc; is_delay_slot = ds; exc_flags = flags;
    data_badaddr = bad; eret = er;
    step();
    valid_in = 1'b0; exc_flags = 7'd0; eret = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".busy"},  32'(busy), 32'd0);
    checkOutput({tag, ".flush"}, 32'(flush), 32'd0);
    checkOutput({tag, ".we"},    cp0_we, 32'd0);
  endtask

  // Checks the WRITE cycle and the flush tail. It can also present an RI
  // during FLUSH, which the controller must ignore.
  task automatic runEvent(input string tag, input bit inject);
    checkOutput({tag, ".we"},      cp0_we, expWe);
    checkOutput({tag, ".epc"},     cp0_epc, expEpc);
    checkOutput({tag, ".bad"},     cp0_badaddr, expBad);
    checkOutput({tag, ".code"},    32'(cp0_exccode), 32'(expCode));
    checkOutput({tag, ".bd"},      32'(cp0_branch_delay), 32'(expBd));
    checkOutput({tag, ".hwint"},   32'(cp0_hw_int), 32'(expHw));
    checkOutput({tag, ".swint"},   32'(cp0_sw_int), 32'd0);
    checkOutput({tag, ".inten"},   32'(cp0_int_enable), 32'(expIntEn));
    checkOutput({tag, ".exl"},     32'(cp0_exl), 32'(expExl));
    checkOutput({tag, ".ie"},      32'(cp0_ie), 32'(expIe));
    checkOutput({tag, ".rpc"},     redirect_pc, expRpc);
    checkOutput({tag, ".rv"},      32'(redirect_valid), 32'd1);
    checkOutput({tag, ".flush"},   32'(flush), 32'd1);
    checkOutput({tag, ".busy"},    32'(busy), 32'd1);
    for (int k = 0; k < FC; k++) begin
      step();
      if (inject && k == 0) begin
        valid_in = 1'b1; exc_flags = 7'b0000010;
      end else begin
        valid_in = 1'b0; exc_flags = 7'd0;
      end
      checkOutput({tag, ".fl.flush"}, 32'(flush), 32'd1);
      checkOutput({tag, ".fl.rv"},    32'(redirect_valid), 32'd0);
      checkOutput({tag, ".fl.we"},    cp0_we, 32'd0);
      checkOutput({tag, ".fl.busy"},  32'(busy), 32'd1);
    end
    valid_in = 1'b0; exc_flags = 7'd0;
    step();
    checkIdle({tag, ".done"});
  endtask

  task automatic checkResult(input string tag);
    if (expAccept) runEvent(tag, 1'b0);
    else           checkIdle(tag);
  endtask

  initial begin
    rst = 1'b1; valid_in = 0; pc_in = 0; is_delay_slot = 0; exc_flags = 0;
    data_badaddr = 0; eret = 0; hw_int = 0; status_in = 0; epc_in = 0;
    #1;
    checkIdle("reset");
    checkOutput("reset.rv",  32'(redirect_valid), 32'd0);
    checkOutput("reset.rpc", redirect_pc, 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // RI, not in a delay slot.
    status_in = 32'h0000_FF01;
    applyStimulus(1, 32'h8000_0100, 0, 7'b0000010, 32'h0, 0);
    runEvent("ri", 1'b0);

    // Data AdES in a delay slot.
    applyStimulus(1, 32'h8000_0200, 1, 7'b1000000, 32'h0000_0003, 0);
    runEvent("ades", 1'b0);

    // One-cycle interrupt pulse, then an instruction two edges later.
    status_in = 32'h0000_0401;
    hw_int = 6'b000001; step(); hw_int = 6'b0; step();
    applyStimulus(1, 32'h8000_0300, 0, 7'd0, 32'h0, 0);
    checkOutput("int.accept", 32'(expAccept), 32'd1);
    checkResult("int");

    // Same pulse with EXL set: masked.
    status_in = 32'h0000_0403;
    hw_int = 6'b000001; step(); hw_int = 6'b0; step();
    applyStimulus(1, 32'h8000_0300, 0, 7'd0, 32'h0, 0);
    checkIdle("intmasked");

    // ERET.
    status_in = 32'h0000_FF03; epc_in = 32'h8000_0400;
    applyStimulus(1, 32'h8000_0500, 0, 7'd0, 32'h0, 1);
    runEvent("eret", 1'b0);

    // Ov + Syscall + ERET: Ov wins, and an RI shown during FLUSH is dropped.
    status_in = 32'h0000_FF01;
    applyStimulus(1, 32'h8000_0600, 0, 7'b0001100, 32'h0, 1);
    runEvent("ovsys", 1'b1);

    // Reset pulsed during FLUSH.
    applyStimulus(1, 32'h8000_0700, 0, 7'b0000010, 32'h0, 0);
    runEvent("prerst.w", 1'b0);
    applyStimulus(1, 32'h8000_0704, 0, 7'b0000010, 32'h0, 0);
    step();
    checkOutput("prerst.flush", 32'(flush), 32'd1);
    rst = 1'b1;
    #1;
    checkIdle("rstflush");
    checkOutput("rstflush.rv",  32'(redirect_valid), 32'd0);
    checkOutput("rstflush.rpc", redirect_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    applyStimulus(1, 32'h8000_0800, 0, 7'b0000010, 32'h0, 0);
    runEvent("postrst", 1'b0);

    // Randomized events against the model.
    for (int n = 0; n < 40; n++) begin
      logic [6:0] fl;
      status_in = {16'h0, 8'($urandom), 6'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom)};
      epc_in    = $urandom;
      hw_int    = 6'($urandom);
      step(); step();
      fl = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom);
      applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), fl,
                    $urandom, 1'($urandom));
      checkResult("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
